// File: rtl/vga_timing_gen.sv
// vga_timing_gen: video timing generator with HS/VS/BLANK, pixel coordinates, strobes, lookahead FIFO read and underflow count
// Ports: pixel_clk/pixel_rst_n clock and async active-low reset; src_ready async "source primed";
// src_empty FIFO empty; running sticky active flag; hs/vs syncs; blank visible-pixel enable;
// rd FIFO read strobe leading blank by RD_LAT; x/y active coordinates; sof/sol frame/line pulses;
// underflow sticky flag and underflow_cnt saturating count of reads from an empty FIFO.
module vga_timing_gen #(
    parameter int HDISP  = 800,
    parameter int VDISP  = 480,
    parameter int HFP    = 40,
    parameter int HPULSE = 48,
    parameter int HBP    = 40,
    parameter int VFP    = 13,
    parameter int VPULSE = 3,
    parameter int VBP    = 29,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0,
    parameter int RD_LAT = 1,
    parameter int UCNT_W = 16
) (
    input  logic                       pixel_clk,
    input  logic                       pixel_rst_n,
    input  logic                       src_ready,
    input  logic                       src_empty,
    output logic                       running,
    output logic                       hs,
    output logic                       vs,
    output logic                       blank,
    output logic                       rd,
    output logic [$clog2(HDISP)-1:0]   x,
    output logic [$clog2(VDISP)-1:0]   y,
    output logic                       sof,
    output logic                       sol,
    output logic                       underflow,
    output logic [UCNT_W-1:0]          underflow_cnt
);
    localparam int HTOT = HDISP + HFP + HPULSE + HBP;
    localparam int VTOT = VDISP + VFP + VPULSE + VBP;
    localparam int HA   = HFP + HPULSE + HBP;
    localparam int VA   = VFP + VPULSE + VBP;
    localparam int HW   = $clog2(HTOT);
    localparam int VW   = $clog2(VTOT);
    localparam int XW   = $clog2(HDISP);
    localparam int YW   = $clog2(VDISP);
    localparam logic [0:0] WAIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [1:0]        sync_q, sync_d;
    logic              start_q, start_d;
    logic [0:0]        state_q, state_d;
    logic [HW-1:0]     hc_q, hc_d;
    logic [VW-1:0]     vc_q, vc_d;
    logic              hs_q, hs_d, vs_q, vs_d, blank_q, blank_d, rd_q, rd_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic              sof_q, sof_d, sol_q, sol_d, underflow_q, underflow_d;
    logic [UCNT_W-1:0] ucnt_q, ucnt_d;
    logic              run, hwrap, vis_v, uf;
    logic [HW:0]       hla;

    always_comb begin
        sync_d      = {sync_q[0], src_ready};
        start_d     = start_q | sync_q[1];
        state_d     = (state_q == WAIT && start_q) ? RUN : state_q;
        run         = state_q == RUN;
        hwrap       = hc_q == HW'(HTOT - 1);
        hc_d        = (!run || hwrap) ? '0 : hc_q + HW'(1);
        vc_d        = !run ? '0 : hwrap ? ((vc_q == VW'(VTOT - 1)) ? '0 : vc_q + VW'(1)) : vc_q;
        // one extra bit so the lookahead past the end of the line is seen, not wrapped
        hla         = {1'b0, hc_q} + (HW+1)'(RD_LAT);
        vis_v       = vc_q >= VW'(VA);
        hs_d        = (run && hc_q >= HW'(HFP) && hc_q < HW'(HFP + HPULSE)) ? HS_POL : ~HS_POL;
        vs_d        = (run && vc_q >= VW'(VFP) && vc_q < VW'(VFP + VPULSE)) ? VS_POL : ~VS_POL;
        blank_d     = run && vis_v && hc_q >= HW'(HA);
        rd_d        = run && vis_v && hla >= (HW+1)'(HA) && hla < (HW+1)'(HTOT);
        x_d         = blank_d ? XW'(hc_q - HW'(HA)) : '0;
        y_d         = blank_d ? YW'(vc_q - VW'(VA)) : '0;
        sol_d       = run && hc_q == '0;
        sof_d       = run && hc_q == '0 && vc_q == '0;
        uf          = rd_q && src_empty;
        underflow_d = underflow_q | uf;
        ucnt_d      = (uf && !(&ucnt_q)) ? ucnt_q + UCNT_W'(1) : ucnt_q;
    end

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            sync_q      <= '0;
            start_q     <= 1'b0;
            state_q     <= WAIT;
            hc_q        <= '0;
            vc_q        <= '0;
            hs_q        <= ~HS_POL;
            vs_q        <= ~VS_POL;
            blank_q     <= 1'b0;
            rd_q        <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            sof_q       <= 1'b0;
            sol_q       <= 1'b0;
            underflow_q <= 1'b0;
            ucnt_q      <= '0;
        end else begin
            sync_q      <= sync_d;
            start_q     <= start_d;
            state_q     <= state_d;
            hc_q        <= hc_d;
            vc_q        <= vc_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            blank_q     <= blank_d;
            rd_q        <= rd_d;
            x_q         <= x_d;
            y_q         <= y_d;
            sof_q       <= sof_d;
            sol_q       <= sol_d;
            underflow_q <= underflow_d;
            ucnt_q      <= ucnt_d;
        end
    end

    assign running       = state_q == RUN;
    assign hs            = hs_q;
    assign vs            = vs_q;
    assign blank         = blank_q;
    assign rd            = rd_q;
    assign x             = x_q;
    assign y             = y_q;
    assign sof           = sof_q;
    assign sol           = sol_q;
    assign underflow     = underflow_q;
    assign underflow_cnt = ucnt_q;
endmodule
